// File: rtl/regfile_2r1w_sb_if.sv
// Decode/writeback bundle for regfile_2r1w_sb.
//   rd_en, rd_addr1/2           : read request (decode)
//   rd_data1/2, rd_busy1/2      : registered read results and scoreboard flags
//   wr_en, wr_addr, wr_data     : writeback port
//   busy_set, busy_addr         : mark a register as awaiting writeback
//   busy_count                  : number of registers currently busy
// master = decode/writeback side, slave = register file.
interface regfile_2r1w_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
  );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with registered read ports and a
// per-register pending-write scoreboard for load-use stall detection.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset, clears data, busy bits, outputs, count
//   bus   : regfile_2r1w_sb_if.slave (read, write, busy-mark, busy_count)
// Only addresses 0..READ_LIMIT are implemented; above that reads return 0/not
// busy and writes/busy marks are dropped.
// Optional feature: define REGFILE_BYPASS_EN to make a same-cycle read of a
// register being written or marked return the post-edge data and busy bit.
// Without it, same-cycle reads return the pre-edge contents.
module regfile_2r1w_sb #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned READ_LIMIT = 23
) (
  input logic              clk,
  input logic              rst_n,
  regfile_2r1w_sb_if.slave bus
);

  localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LimitAddr = ADDR_W'(READ_LIMIT);

  if (READ_LIMIT >= NUM_REGS) begin : g_bad_limit
    $error("READ_LIMIT must be below 2**ADDR_W");
  end

  // Storage is sized to the full address space; entries above the window are
  // never written and stay at their reset value.
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic wr_ok, set_ok, inc, dec;

  logic [ADDR_W-1:0] rd_addr   [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic [DATA_W-1:0] rd_data_q [2];
  logic [1:0]        rd_busy_d, rd_busy_q;

  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;

  assign wr_ok  = bus.wr_en    && (bus.wr_addr   <= LimitAddr);
  assign set_ok = bus.busy_set && (bus.busy_addr <= LimitAddr);

  // Clear first, then set: on a same-address write+set the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.wr_addr]   = 1'b0;
    if (set_ok) busy_d[bus.busy_addr] = 1'b1;
  end

  // Incremental popcount tracking. A write only decrements when it actually
  // clears a busy bit, i.e. not when a set lands on the same register.
  always_comb begin
    inc     = set_ok && !busy_q[bus.busy_addr];
    dec     = wr_ok && busy_q[bus.wr_addr] && !(set_ok && (bus.busy_addr == bus.wr_addr));
    count_d = count_q + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_d[p] = '0;
      rd_busy_d[p] = 1'b0;
      if (rd_addr[p] <= LimitAddr) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.wr_addr == rd_addr[p])) begin
          rd_data_d[p] = bus.wr_data;
        end else begin
          rd_data_d[p] = mem_q[rd_addr[p]];
        end
        rd_busy_d[p] = busy_d[rd_addr[p]];
`else
        rd_data_d[p] = mem_q[rd_addr[p]];
        rd_busy_d[p] = busy_q[rd_addr[p]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
      rd_busy_q    <= '0;
    end else if (bus.rd_en) begin
      rd_data_q[0] <= rd_data_d[0];
      rd_data_q[1] <= rd_data_d[1];
      rd_busy_q    <= rd_busy_d;
    end
  end

  assign bus.rd_data1   = rd_data_q[0];
  assign bus.rd_data2   = rd_data_q[1];
  assign bus.rd_busy1   = rd_busy_q[0];
  assign bus.rd_busy2   = rd_busy_q[1];
  assign bus.busy_count = count_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb. The stimulus process pushes expected
// results into a scoreboard tagged with the cycle they become visible; a
// separate monitor pops and compares them on the falling edge.
module tb_regfile_2r1w_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_2r1w_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_2r1w_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LIMIT(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned       due;
    string             name;
    bit                has_rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              b1;
    logic              b2;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void expect_rd(input string name, input logic [DATA_W-1:0] d1,
                                    input logic [DATA_W-1:0] d2, input logic b1,
                                    input logic b2, input logic [ADDR_W:0] cnt);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.has_rd = 1'b1;
    e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.cnt = cnt;
    sb.push_back(e);
  endfunction

  function automatic void expect_cnt(input string name, input logic [ADDR_W:0] cnt);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.has_rd = 1'b0;
    e.d1 = '0; e.d2 = '0; e.b1 = 1'b0; e.b2 = 1'b0; e.cnt = cnt;
    sb.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) check({e.name, "_due"}, 64'(cyc), 64'(e.due));
      check({e.name, "_cnt"}, 64'(bus.busy_count), 64'(e.cnt));
      if (e.has_rd) begin
        check({e.name, "_d1"}, 64'(bus.rd_data1), 64'(e.d1));
        check({e.name, "_d2"}, 64'(bus.rd_data2), 64'(e.d2));
        check({e.name, "_b1"}, 64'(bus.rd_busy1), 64'(e.b1));
        check({e.name, "_b2"}, 64'(bus.rd_busy2), 64'(e.b2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.wr_en    = 1'b0;
    bus.busy_set = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d;
  endtask

  task automatic bset(input int a);
    bus.busy_set = 1'b1; bus.busy_addr = ADDR_W'(a);
  endtask

  task automatic rd(input int a1, input int a2);
    bus.rd_en = 1'b1; bus.rd_addr1 = ADDR_W'(a1); bus.rd_addr2 = ADDR_W'(a2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.busy_set = 1'b0; bus.busy_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    rd(0, 17); expect_rd("por", 0, 0, 0, 0, 0); tick();

    // Reset after some activity
    wr(0, 32'hAAAA); bset(17); expect_cnt("pre_set17", 1); tick();
    wr(17, 32'h1234); bset(0); expect_cnt("net_zero", 1); tick();
    rst_n = 1'b0; expect_cnt("rst_a", 0); tick();
    expect_cnt("rst_b", 0); tick();
    rst_n = 1'b1;
    rd(0, 17); expect_rd("after_rst", 0, 0, 0, 0, 0); tick();

    // Write then read
    wr(16, 32'd10); tick();
    wr(17, 32'd2); tick();
    rd(16, 17); expect_rd("wr_rd", 32'd10, 32'd2, 0, 0, 0); tick();
    bus.rd_addr1 = 5'd24; bus.rd_addr2 = 5'd0;
    expect_rd("hold", 32'd10, 32'd2, 0, 0, 0); tick();

    // Window limit
    wr(24, 32'hDEADBEEF); bset(30); expect_cnt("oow_cnt", 0); tick();
    rd(24, 30); expect_rd("oow_rd", 0, 0, 0, 0, 0); tick();
    wr(23, 32'hCAFE); bset(23); expect_cnt("lim_set", 1); tick();
    wr(23, 32'hCAFE); expect_cnt("lim_clr", 0); tick();
    rd(23, 23); expect_rd("lim_rd", 32'hCAFE, 32'hCAFE, 0, 0, 0); tick();

    // Scoreboard
    bset(5); expect_cnt("sb_1", 1); tick();
    bset(6); expect_cnt("sb_2", 2); tick();
    wr(5, 32'h50); expect_cnt("sb_3", 1); tick();
    bset(6); wr(6, 32'h60); expect_cnt("sb_4", 1); tick();
    rd(6, 5); expect_rd("sb_rd", 32'h60, 32'h50, 1, 0, 1); tick();

    // Same-cycle read vs write/busy mark
    wr(3, 32'h11); tick();
`ifdef REGFILE_BYPASS_EN
    wr(3, 32'h55); rd(3, 3); expect_rd("byp_wr", 32'h55, 32'h55, 0, 0, 1); tick();
    bset(3); wr(3, 32'h77); rd(3, 3); expect_rd("byp_set", 32'h77, 32'h77, 1, 1, 2); tick();
`else
    wr(3, 32'h55); rd(3, 3); expect_rd("byp_wr", 32'h11, 32'h11, 0, 0, 1); tick();
    bset(3); wr(3, 32'h77); rd(3, 3); expect_rd("byp_set", 32'h55, 32'h55, 0, 0, 2); tick();
`endif
    rd(3, 6); expect_rd("post_byp", 32'h77, 32'h60, 1, 1, 2); tick();

    // Reset beats a same-cycle write and busy mark
    rst_n = 1'b0; wr(7, 32'h99); bset(7); rd(7, 7);
    expect_rd("mid_rst", 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1;
    rd(7, 3); expect_rd("mid_rst_rd", 0, 0, 0, 0, 0); tick();

    tick(); tick(); tick();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
